// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the AES decryption-core scheduler.
package aes_sched_pkg;

  localparam int KEY_W = 128;
  localparam int TXT_W = 128;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_KLOAD = 3'd1;
  localparam state_t S_KWAIT = 3'd2;
  localparam state_t S_LOAD  = 3'd3;
  localparam state_t S_BUSY  = 3'd4;
  localparam state_t S_RESP  = 3'd5;

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module aes_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0] upper;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_upper
      assign upper[gi] = req[gi] && (IDX_W'(gi) >= ptr);
    end
  endgenerate

  // Lowest request at/after ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) idx = IDX_W'(k);
    end
    if (|upper) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (upper[k]) idx = IDX_W'(k);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/aes_inv_sched.sv
// Shares one AES inverse-cipher core among NREQ requesters with a one-entry
// expanded-key cache, round-robin grant and a done timeout.
module aes_inv_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int KEY_WAIT     = 12,
  parameter int DONE_TIMEOUT = 31,
  localparam int IDX_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*KEY_W-1:0] req_key,
  input  logic [NREQ*TXT_W-1:0] req_text,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDX_W-1:0]      rsp_id,
  output logic [TXT_W-1:0]      rsp_data,
  output logic                  rsp_err,
  input  logic                  key_flush,
  output logic                  core_kld,
  output logic                  core_ld,
  output logic [KEY_W-1:0]      core_key,
  output logic [TXT_W-1:0]      core_text_in,
  input  logic                  core_done,
  input  logic [TXT_W-1:0]      core_text_out
);

  localparam int WCNT_W = $clog2(KEY_WAIT + 1);
  localparam int TCNT_W = $clog2(DONE_TIMEOUT + 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic                key_vld_reg;
  logic [KEY_W-1:0]    cache_key_reg;
  logic [WCNT_W-1:0]   wcnt_reg;
  logic [TCNT_W-1:0]   tcnt_reg;
  logic [TCNT_W-1:0]   tcnt_inc;

  logic [KEY_W-1:0]    key_arr  [NREQ];
  logic [TXT_W-1:0]    text_arr [NREQ];
  logic [NREQ-1:0]     arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic                grant_ok;
  logic                cache_hit;
  logic [IDX_W-1:0]    rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign key_arr[gi]  = req_key[KEY_W*gi +: KEY_W];
      assign text_arr[gi] = req_text[TXT_W*gi +: TXT_W];
    end
  endgenerate

  aes_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Grants are suppressed while reset is held so no request is silently dropped.
  assign grant_ok    = rst && (state_reg == S_IDLE) && arb_any;
  assign req_ready   = arb_grant & {NREQ{grant_ok}};
  assign cache_hit   = key_vld_reg && (key_arr[arb_idx] == cache_key_reg);
  assign rr_ptr_next = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
  assign tcnt_inc    = tcnt_reg + 1'b1;

  assign core_kld  = (state_reg == S_KLOAD);
  assign core_ld   = (state_reg == S_LOAD);
  assign rsp_valid = (state_reg == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= '0;
      key_vld_reg   <= 1'b0;
      cache_key_reg <= '0;
      wcnt_reg      <= '0;
      tcnt_reg      <= '0;
      core_key      <= '0;
      core_text_in  <= '0;
      rsp_id        <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_ok) begin
            core_key     <= key_arr[arb_idx];
            core_text_in <= text_arr[arb_idx];
            rsp_id       <= arb_idx;
            rr_ptr_reg   <= rr_ptr_next;
            state_reg    <= cache_hit ? S_LOAD : S_KLOAD;
          end
        end
        S_KLOAD: begin
          key_vld_reg <= 1'b0;
          wcnt_reg    <= '0;
          state_reg   <= S_KWAIT;
        end
        S_KWAIT: begin
          if (wcnt_reg == WCNT_W'(KEY_WAIT - 1)) begin
            key_vld_reg   <= 1'b1;
            cache_key_reg <= core_key;
            state_reg     <= S_LOAD;
          end else begin
            wcnt_reg <= wcnt_reg + 1'b1;
          end
        end
        S_LOAD: begin
          tcnt_reg  <= '0;
          state_reg <= S_BUSY;
        end
        S_BUSY: begin
          if (core_done) begin
            rsp_data  <= core_text_out;
            rsp_err   <= 1'b0;
            state_reg <= S_RESP;
          end else if (tcnt_inc == TCNT_W'(DONE_TIMEOUT - 1)) begin
            // A hung core may hold a corrupt schedule, so drop the cached key too.
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            key_vld_reg <= 1'b0;
            state_reg   <= S_RESP;
          end else begin
            tcnt_reg <= tcnt_inc;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
      if (key_flush) key_vld_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_inv_sched.sv
// Directed bench for aes_inv_sched with a behavioural 12-cycle core stand-in
// that answers with FIPS-197 plaintexts for the key it was last loaded with.
module tb_aes_inv_sched;

  localparam int NREQ = 2;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*128-1:0] req_key = '0;
  logic [NREQ*128-1:0] req_text = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [0:0]       rsp_id;
  logic [127:0]     rsp_data;
  logic             rsp_err;
  logic             key_flush = 1'b0;
  logic             core_kld;
  logic             core_ld;
  logic [127:0]     core_key;
  logic [127:0]     core_text_in;
  logic             core_done = 1'b0;
  logic [127:0]     core_text_out = '0;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  aes_inv_sched #(.NREQ(NREQ), .KEY_WAIT(12), .DONE_TIMEOUT(31)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .req_text      (req_text),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .key_flush     (key_flush),
    .core_kld      (core_kld),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text_in  (core_text_in),
    .core_done     (core_done),
    .core_text_out (core_text_out)
  );

  // Core stand-in: core_done arrives 12 cycles after core_ld.
  logic         core_en = 1'b1;
  logic         mbusy = 1'b0;
  int           mcnt = 0;
  logic [127:0] mkey = '0;
  logic [127:0] mtxt = '0;

  function automatic logic [127:0] model_pt(input logic [127:0] k, input logic [127:0] c);
    if (k == K1 && c == C1) return P1;
    if (k == K2 && c == C2) return P2;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_kld) mkey <= core_key;
    if (core_ld) begin
      mtxt  <= core_text_in;
      mcnt  <= 11;
      mbusy <= 1'b1;
    end else if (mbusy) begin
      if (mcnt == 1) begin
        mbusy <= 1'b0;
        if (core_en) begin
          core_done     <= 1'b1;
          core_text_out <= model_pt(mkey, mtxt);
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Event timing relative to the grant cycle (cycle 0).
  int t = 0, nkld = 0, kld_cyc = -1, ld_cyc = -1, rsp_cyc = -1;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (|req_ready) begin
      t <= 0; nkld <= 0; kld_cyc <= -1; ld_cyc <= -1; rsp_cyc <= -1;
    end else begin
      t <= t + 1;
      if (core_kld) begin nkld <= nkld + 1; kld_cyc <= t + 1; end
      if (core_ld) ld_cyc <= t + 1;
      if (rsp_valid && rsp_cyc < 0) rsp_cyc <= t + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs == exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'd0);
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
    chk({tag, "_core_kld"}, 128'(core_kld), 128'd0);
    chk({tag, "_core_ld"}, 128'(core_ld), 128'd0);
    chk({tag, "_core_key"}, core_key, 128'd0);
    chk({tag, "_core_text_in"}, core_text_in, 128'd0);
    chk({tag, "_rsp_id"}, 128'(rsp_id), 128'd0);
    chk({tag, "_rsp_data"}, rsp_data, 128'd0);
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'd0);
  endtask

  task automatic wait_grant(input int exp_id);
    int n = 0;
    #1;
    while (!(|req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chki("grant_seen", int'(|req_ready), 1);
    chki("grant_id", onehot_idx(req_ready), exp_id);
  endtask

  task automatic issue(input int id, input logic [127:0] key, input logic [127:0] text);
    @(posedge clk); #1;
    req_key[128*id +: 128]  = key;
    req_text[128*id +: 128] = text;
    req_valid[id] = 1'b1;
    wait_grant(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input logic [127:0] data, input logic err,
                          input int nk, input int ld, input int rc, input int hold);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chki("rsp_seen", int'(rsp_valid), 1);
    chki("rsp_id", int'(rsp_id), id);
    chk("rsp_data", rsp_data, data);
    chk("rsp_err", 128'(err ? 1 : 0), 128'(rsp_err));
    chki("kld_count", nkld, nk);
    chki("kld_cycle", kld_cyc, (nk > 0) ? 1 : -1);
    chki("ld_cycle", ld_cyc, ld);
    chki("rsp_cycle", rsp_cyc, rc);
    $display("rsp id=%0d data=%h err=%0b kld=%0d ld@%0d rsp@%0d", rsp_id, rsp_data, rsp_err,
             nkld, ld_cyc, rsp_cyc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 128'(rsp_valid), 128'd1);
      chk("hold_data", rsp_data, data);
      chki("hold_id", int'(rsp_id), id);
      chk("hold_err", 128'(rsp_err), 128'(err ? 1 : 0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 128'(rsp_valid), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: requests presented during reset must not be accepted.
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single miss on requester 0.
    issue(0, K1, C1);
    wait_rsp(0, P1, 1'b0, 1, 14, 27, 0);

    // Same key from requester 1 hits the cache.
    issue(1, K1, C1);
    wait_rsp(1, P1, 1'b0, 0, 1, 14, 0);

    // Contention, rr_ptr back at 0: grants 0,1,0 with alternating keys.
    @(posedge clk); #1;
    req_key  = {K1, K2};
    req_text = {C1, C2};
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_grant(k % 2);
      @(posedge clk); #1;
      if (k == 1) req_valid[1] = 1'b0;
      if (k == 2) req_valid[0] = 1'b0;
      wait_rsp(k % 2, (k % 2 == 1) ? P1 : P2, 1'b0, 1, 14, 27, 0);
    end

    // Flush on the last KWAIT cycle beats the cache fill.
    issue(0, K1, C1);
    repeat (13) @(negedge clk);
    key_flush = 1'b1;
    @(negedge clk);
    key_flush = 1'b0;
    wait_rsp(0, P1, 1'b0, 1, 14, 27, 0);
    issue(1, K1, C1);
    wait_rsp(1, P1, 1'b0, 1, 14, 27, 0);
    issue(0, K1, C1);
    wait_rsp(0, P1, 1'b0, 0, 1, 14, 0);

    // Timeout on a cache hit, then the cached key is gone.
    core_en = 1'b0;
    issue(0, K1, C1);
    wait_rsp(0, 128'd0, 1'b1, 0, 1, 32, 0);
    core_en = 1'b1;
    repeat (2) @(negedge clk);
    issue(1, K1, C1);
    wait_rsp(1, P1, 1'b0, 1, 14, 27, 0);

    // Backpressure: response held stable for 10 cycles.
    issue(1, K1, C1);
    wait_rsp(1, P1, 1'b0, 0, 1, 14, 10);

    // Reset mid-BUSY; the late core_done must be ignored and the cache is cold.
    issue(0, K1, C1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("midrst");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_rst", 128'(rsp_valid), 128'd0);
    issue(0, K1, C1);
    wait_rsp(0, P1, 1'b0, 1, 14, 27, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
